// File: rtl/pwm.sv
// Single-channel fixed-period PWM generator.
// A free-running period counter is compared against a duty register that
// reloads from the command input only at the period wrap. Because of that,
// a command change can never shorten or split a pulse that is in progress.
module pwm #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] Input,
    output logic             OUT
);

    // Prescaler width: clog2(PRESCALE), but never narrower than one bit.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] CNT_LAST = '1;

    logic [PW-1:0]    pre_cnt_reg;
    logic [PW-1:0]    pre_cnt_next;
    logic [WIDTH-1:0] cnt_reg;
    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] duty_reg;
    logic [WIDTH-1:0] duty_next;
    logic             out_reg;
    logic             out_next;
    logic             tick;

    // With PRESCALE=1 the prescaler stays at 0, so tick is constantly high.
    assign tick = (pre_cnt_reg == PRE_LAST);

    // Next-state logic: prescaler, period counter, duty reload, comparator.
    always_comb begin
        pre_cnt_next = pre_cnt_reg;
        cnt_next     = cnt_reg;
        duty_next    = duty_reg;
        out_next     = 1'b0;

        if (tick) begin
            pre_cnt_next = '0;
        end else begin
            pre_cnt_next = pre_cnt_reg + 1'b1;
        end

        if (tick) begin
            if (cnt_reg == CNT_LAST) begin
                // Period boundary: the only place the command is sampled.
                cnt_next  = '0;
                duty_next = Input;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end

        // Compare uses the current registers, so OUT lags cnt by one clock.
        // duty can never exceed the counter's last value, so 100% is unreachable.
        out_next = (cnt_reg < duty_reg);
    end

    // State registers; reset overrides every other update.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pre_cnt_reg <= '0;
            cnt_reg     <= '0;
            duty_reg    <= '0;
            out_reg     <= 1'b0;
        end else begin
            pre_cnt_reg <= pre_cnt_next;
            cnt_reg     <= cnt_next;
            duty_reg    <= duty_next;
            out_reg     <= out_next;
        end
    end

    assign OUT = out_reg;

endmodule

// File: tb/tb_pwm.sv
// Directed testbench for pwm: one instance with PRESCALE=1, one with PRESCALE=3.
module tb_pwm;

    logic       clk = 1'b0;
    logic       rst1, rst3;
    logic [3:0] in1, in3;
    logic       out1, out3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pwm #(.WIDTH(4), .PRESCALE(1)) dut1 (
        .CLK(clk), .RST(rst1), .Input(in1), .OUT(out1)
    );

    pwm #(.WIDTH(4), .PRESCALE(3)) dut3 (
        .CLK(clk), .RST(rst3), .Input(in3), .OUT(out3)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    // Sample n clocks of one instance's output at the falling edge.
    // lead  = length of the leading run of high samples
    // total = number of high samples in the window
    // If sw_at >= 0, the command input is changed to sw_val after sw_at samples.
    task automatic measure(input int which, input int n, input int sw_at,
                           input int sw_val, output int lead, output int total);
        logic o;
        bit   in_lead;
        in_lead = 1'b1;
        lead    = 0;
        total   = 0;
        for (int i = 0; i < n; i++) begin
            if (i == sw_at) begin
                if (which == 1) in1 = sw_val[3:0];
                else            in3 = sw_val[3:0];
            end
            @(negedge clk);
            o = (which == 1) ? out1 : out3;
            if (o) total++;
            if (o && in_lead) lead++;
            else              in_lead = 1'b0;
        end
    endtask

    initial begin
        int lead, total;

        rst1 = 1'b1; in1 = 4'd8;
        rst3 = 1'b1; in3 = 4'd5;

        // Reset: 10 cycles, output must stay low.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("p1_out_in_reset", int'(out1), 0);
        end
        rst1 = 1'b0;

        // First period after release: duty register is still 0.
        measure(1, 16, -1, 0, lead, total);
        check("p1_first_period_high", total, 0);

        // Steady state with Input=8: 8 high then 8 low, four periods.
        for (int p = 0; p < 4; p++) begin
            measure(1, 16, -1, 0, lead, total);
            check("p1_d8_lead_high", lead, 8);
            check("p1_d8_total_high", total, 8);
        end

        // Input=0: discard one period for the reload, then never high.
        in1 = 4'd0;
        measure(1, 16, -1, 0, lead, total);
        for (int p = 0; p < 2; p++) begin
            measure(1, 16, -1, 0, lead, total);
            check("p1_d0_total_high", total, 0);
        end

        // Input=15: 15 high, 1 low each period.
        in1 = 4'd15;
        measure(1, 16, -1, 0, lead, total);
        for (int p = 0; p < 2; p++) begin
            measure(1, 16, -1, 0, lead, total);
            check("p1_d15_lead_high", lead, 15);
            check("p1_d15_total_high", total, 15);
        end

        // Mid-period change: Input=4, switched to 12 when cnt reaches 6.
        in1 = 4'd4;
        measure(1, 16, -1, 0, lead, total);
        measure(1, 16, 6, 12, lead, total);
        check("p1_mid_cur_lead", lead, 4);
        check("p1_mid_cur_total", total, 4);
        measure(1, 16, -1, 0, lead, total);
        check("p1_mid_next_lead", lead, 12);
        check("p1_mid_next_total", total, 12);

        // Reset mid-operation while the output is high.
        measure(1, 3, -1, 0, lead, total);
        check("p1_pre_reset_high", int'(out1), 1);
        rst1 = 1'b1;
        @(negedge clk);
        check("p1_out_after_reset_edge", int'(out1), 0);
        in1 = 4'd8;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("p1_out_in_reset2", int'(out1), 0);
        end
        rst1 = 1'b0;
        measure(1, 16, -1, 0, lead, total);
        check("p1_rerelease_first_period", total, 0);
        for (int p = 0; p < 2; p++) begin
            measure(1, 16, -1, 0, lead, total);
            check("p1_rerelease_lead", lead, 8);
            check("p1_rerelease_total", total, 8);
        end

        // Prescaler: PRESCALE=3, Input=5 -> 48-clock period, 15 high, 33 low.
        @(negedge clk);
        check("p3_out_in_reset", int'(out3), 0);
        rst3 = 1'b0;
        measure(3, 48, -1, 0, lead, total);
        check("p3_first_period_high", total, 0);
        for (int p = 0; p < 2; p++) begin
            measure(3, 48, -1, 0, lead, total);
            check("p3_d5_lead_high", lead, 15);
            check("p3_d5_total_high", total, 15);
            check("p3_d5_total_low", 48 - total, 33);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
